// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

   // Transmit bit-timing FSM states.
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   // Register offsets from the window base.
   localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
   localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

   // STATUS bit positions.
   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_FULL    = 1;
   localparam int unsigned STAT_EMPTY   = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_W   = 4;

   // Assemble the STATUS word; unlisted bits read as zero.
   function automatic logic [31:0] pack_status(input logic                  busy,
                                               input logic                  full,
                                               input logic                  empty,
                                               input logic                  ovf,
                                               input logic [STAT_CNT_W-1:0] cnt);
      logic [31:0] s;
      s                             = '0;
      s[STAT_BUSY]                  = busy;
      s[STAT_FULL]                  = full;
      s[STAT_EMPTY]                 = empty;
      s[STAT_OVF]                   = ovf;
      s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; push-when-full only lands with a pop.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         data_i,
   output logic [Width-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   // Next-state for pointers and occupancy; pointers wrap at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS is read combinationally.
module mmio_uart_tx import uart_pkg::*; #(
   parameter logic [31:0] BASE_ADR     = 32'h0000_1000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        tx
);

   localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW-1:0] BitCntLast = CntW'(CLKS_PER_BIT - 1);

   tx_state_t             state_q, state_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [2:0]            bit_idx_q, bit_idx_d;
   logic [7:0]            shift_q, shift_d;
   logic                  ovf_q, ovf_d;
   logic                  tx_q, tx_d;

   logic                  hit_data_wr, hit_stat_wr, hit_stat_rd;
   logic                  fifo_pop, fifo_full, fifo_empty;
   logic [7:0]            fifo_dout;
   logic [FifoCntW-1:0]   fifo_count;
   logic [31:0]           cnt_ext;
   logic                  unused_bits;

   assign hit_data_wr = we && (adr == BASE_ADR + TXDATA_OFS);
   assign hit_stat_wr = we && (adr == BASE_ADR + STATUS_OFS);
   assign hit_stat_rd = (adr == BASE_ADR + STATUS_OFS);

   sync_fifo #(
      .Width (8),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (hit_data_wr),
      .pop_i   (fifo_pop),
      .data_i  (writeData[7:0]),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign cnt_ext     = 32'(fifo_count);
   assign unused_bits = ^{writeData[31:8], cnt_ext[31:STAT_CNT_W]};

   // Sticky overflow: set by a dropped push, cleared by any STATUS write.
   always_comb begin
      ovf_d = ovf_q;
      if (hit_stat_wr) begin
         ovf_d = 1'b0;
      end else if (hit_data_wr && fifo_full && !fifo_pop) begin
         ovf_d = 1'b1;
      end
   end

   // Bit-timing FSM: next state, counters, shift register and FIFO pop.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_dout;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_cnt_q == BitCntLast) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_cnt_q == BitCntLast) begin
               bit_cnt_d = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_cnt_q == BitCntLast) begin
               bit_cnt_d = '0;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level decoded from the next state so tx is a clean register output.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State, counters, shift register, overflow flag and serial line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         ovf_q     <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         ovf_q     <= ovf_d;
         tx_q      <= tx_d;
      end
   end

   assign tx = tx_q;

   // Combinational STATUS read; every other address reads zero.
   always_comb begin
      readData = '0;
      if (hit_stat_rd) begin
         readData = pack_status(state_q != IDLE, fifo_full, fifo_empty, ovf_q,
                                cnt_ext[STAT_CNT_W-1:0]);
      end
   end

endmodule
